seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing controller for the board's common-anode seven-segment display bank. It buffers a multi-digit hex word with a valid/ready load handshake and walks the active-low anode strobes one digit at a time, with a blanking gap between digits to suppress ghosting. Each cycle it presents the 4-bit code and decimal-point bit for the digit being driven. It sits between the FPU result/status path and the hex-to-segment decoder feeding the display pins. New words are swapped in only at frame boundaries, so a displayed frame never mixes two values.

## Interface
- NUM_DIGITS, 4, number of digits/anodes scanned (2..8)
- DIGIT_CYCLES, 50000, clock cycles each digit is driven (>=1)
- BLANK_CYCLES, 2000, clock cycles all anodes are off before each digit (>=1)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  load_data/load_dp valid
- load_ready  out  1  buffer can accept a word
- load_data  in  4*NUM_DIGITS  hex word; digit i = load_data[4i+3:4i]
- load_dp  in  NUM_DIGITS  decimal-point enable per digit, 1 = lit
- an  out  NUM_DIGITS  anode strobes, active-low, at most one low
- digit_code  out  4  hex code of the driven digit, to the segment decoder
- dp_on  out  1  decimal point for the driven digit, 1 = lit
- frame_done  out  1  one-cycle pulse at the end of each full scan

## Operation
- Two buffers: active (displayed) and pending (accepted, not yet shown) with pending_valid flag.
- load_ready = !pending_valid (registered-equivalent, no combinational path from load_valid).
- Handshake: transfer when load_valid && load_ready at rising edge; pending <= {load_data, load_dp}, pending_valid <= 1.
- FSM states: S_BLANK, S_DRIVE. Dwell counter cnt, digit index idx.
  - S_BLANK: cnt counts 0..BLANK_CYCLES-1; on last count -> S_DRIVE, cnt <= 0.
  - S_DRIVE: cnt counts 0..DIGIT_CYCLES-1; on last count -> S_BLANK, cnt <= 0, idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame end = S_DRIVE last count with idx = NUM_DIGITS-1. At that edge: frame_done <= 1 for one cycle; if pending_valid, active <= pending, pending_valid <= 0.
- Simultaneous load and frame end: load_ready is 1 only when pending is empty, so there is no swap; the accepted word stays pending until the next frame end.
- Outputs registered: S_BLANK gives an = all ones; S_DRIVE gives an = ~(1<<idx), digit_code = active digit idx, dp_on = active dp idx. digit_code/dp_on update on entry to S_DRIVE and hold through the following S_BLANK.
- Counter width: $clog2(max(DIGIT_CYCLES, BLANK_CYCLES)); terminal compare exact, no overflow.

## Timing
- Reset values: state S_BLANK, cnt 0, idx 0, an all ones, digit_code 0, dp_on 0, frame_done 0, active 0, pending_valid 0, load_ready 1.
- Reset mid-frame: state, counters and buffers return to their reset values on the next edge; the pending word is discarded.
- Frame period: NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
- After reset, the first anode goes low BLANK_CYCLES cycles after reset deasserts.
- Load-to-display latency: up to one frame, plus BLANK_CYCLES.
- No two anodes are ever low in the same cycle; every low-to-low anode change passes through at least BLANK_CYCLES of all-high.

## Structure
- Shared package seg_scan_pkg: FSM state encodings (S_BLANK=1'b0, S_DRIVE=1'b1) and default dwell constants.
- Sub-module seg_dwell_timer: loadable down-counter with terminal-count flag, reused for both dwell phases.
- Segment decoding stays outside this block. The top level connects digit_code to the 4-bit hex decoder.

## Test plan
Use NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=2 (frame = 24 cycles).
- Reset: hold reset 3 cycles -> an=4'b1111, digit_code=0, dp_on=0, load_ready=1, frame_done=0.
- Scan order: no load -> an sequence 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4; frame_done high exactly at cycle 24; repeats.
- Load and swap: load 16'h1234, dp=4'b0010 at cycle 1 -> load_ready=0 next cycle; frame 1 shows 0,0,0,0. Frame 2 shows 4,3,2,1, with dp_on=1 only while an=1101. load_ready returns to 1 after the first frame_done.
- Backpressure: hold load_valid with 16'hABCD while pending is full -> no transfer until load_ready=1, then exactly one transfer; the value is not lost or duplicated.
- Load on frame-end cycle with pending empty -> the word is not shown in the next frame and appears the frame after.
- Reset asserted while an=1011 -> next cycle an=1111, active cleared, pending discarded; restart timing matches the reset scenario.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared FSM state encodings and default dwell constants for the seven-segment scan controller
package seg_scan_pkg;
  typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_CYCLES = 50000;
  localparam int DEF_BLANK_CYCLES = 2000;
endpackage

// File: rtl/seg_dwell_timer.sv
// seg_dwell_timer: loadable down-counter (clk, rst, reload value in, tc out when count reaches zero, reloads on tc)
module seg_dwell_timer #(
  parameter int W = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] reload,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == '0;
  always_comb cnt_d = tc ? reload : cnt_q - 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= INIT;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered 7-seg scan (load_valid/ready/data/dp in; active-low an, digit_code, dp_on, frame_done out)
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              digit_code,
  output logic                    dp_on,
  output logic                    frame_done
);
  localparam int MAXC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = 5 * NUM_DIGITS;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] active_q, active_d, pending_q, pending_d;
  logic pending_valid_q, pending_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0] code_q, code_d;
  logic dp_q, dp_d, frame_done_q, frame_done_d;
  logic tc, xfer, frame_end, enter;
  logic [CW-1:0] reload;
  // the timer's reload value is the length of the phase being entered on tc
  seg_dwell_timer #(.W(CW), .INIT(CW'(BLANK_CYCLES - 1))) u_timer (
    .clk(clk), .rst(reset), .reload(reload), .tc(tc)
  );
  always_comb begin
    reload = state_q == S_BLANK ? CW'(DIGIT_CYCLES - 1) : CW'(BLANK_CYCLES - 1);
    xfer = load_valid && !pending_valid_q;
    frame_end = tc && state_q == S_DRIVE && idx_q == IW'(NUM_DIGITS - 1);
    enter = tc && state_q == S_BLANK;
    state_d = tc ? state_t'(!state_q) : state_q;
    idx_d = tc && state_q == S_DRIVE ? (frame_end ? '0 : idx_q + 1'b1) : idx_q;
    pending_d = xfer ? {load_data, load_dp} : pending_q;
    // accept and swap are exclusive: accept needs empty pending, swap needs full
    pending_valid_d = xfer || (pending_valid_q && !frame_end);
    active_d = frame_end && pending_valid_q ? pending_q : active_q;
    an_d = state_d == S_DRIVE ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    code_d = enter ? active_q[NUM_DIGITS + 4 * idx_q +: 4] : code_q;
    dp_d = enter ? active_q[idx_q] : dp_q;
    frame_done_d = frame_end;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BLANK;
      idx_q <= '0;
      active_q <= '0;
      pending_q <= '0;
      pending_valid_q <= 1'b0;
      an_q <= '1;
      code_q <= '0;
      dp_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      active_q <= active_d;
      pending_q <= pending_d;
      pending_valid_q <= pending_valid_d;
      an_q <= an_d;
      code_q <= code_d;
      dp_q <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign load_ready = !pending_valid_q;
  assign an = an_q;
  assign digit_code = code_q;
  assign dp_on = dp_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for seg_scan_ctrl with 4 digits, 4-cycle drive, 2-cycle blank
module tb_seg_scan_ctrl;
  typedef struct {
    int cyc;
    logic [3:0] an;
    logic [3:0] code;
    logic dp, fd, rdy;
  } exp_t;
  logic clk = 0, reset = 1, load_valid = 0, load_ready, dp_on, frame_done;
  logic [15:0] load_data = '0;
  logic [3:0] load_dp = '0, an, digit_code;
  exp_t q[$];
  int checks = 0, errors = 0;
  int c = 0;
  logic [15:0] disp_w = '0, pend_w = '0;
  logic [3:0] disp_p = '0, pend_p = '0, lc = '0;
  logic pv = 0, ldp = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .an(an), .digit_code(digit_code),
    .dp_on(dp_on), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({an, digit_code, dp_on, frame_done, load_ready} !== {e.an, e.code, e.dp, e.fd, e.rdy}) begin
        errors++;
        $display("FAIL scan cyc=%0d an=%b want %b code=%h want %h dp=%b want %b fd=%b want %b rdy=%b want %b",
                 e.cyc, an, e.an, digit_code, e.code, dp_on, e.dp, frame_done, e.fd, load_ready, e.rdy);
      end
    end
  end

  // frame = 24 cycles: per digit 2 blank then 4 drive; cycle 0 is the first cycle after reset
  task automatic step(input logic r, input logic lv, input logic [15:0] d, input logic [3:0] p);
    exp_t e;
    int t, dg;
    logic drv, rdy, fe;
    t = c % 24;
    dg = t / 6;
    drv = (t % 6) >= 2;
    if (drv) begin
      lc = disp_w[4*dg +: 4];
      ldp = disp_p[dg];
    end
    e.cyc = c;
    e.an = drv ? ~(4'b0001 << dg) : 4'hF;
    e.code = lc;
    e.dp = ldp;
    e.fd = t == 0 && c > 0;
    e.rdy = !pv;
    q.push_back(e);
    reset = r;
    load_valid = lv;
    load_data = d;
    load_dp = p;
    @(posedge clk);
    #1;
    if (r) begin
      c = 0; disp_w = '0; disp_p = '0; pv = 0; lc = '0; ldp = 0;
    end else begin
      rdy = !pv;
      fe = (c + 1) % 24 == 0;
      if (fe && pv) begin
        disp_w = pend_w; disp_p = pend_p; pv = 0;
      end
      if (lv && rdy) begin
        pend_w = d; pend_p = p; pv = 1;
      end
      c++;
    end
  endtask

  initial begin
    logic lv, r;
    logic [15:0] d;
    logic [3:0] p;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1, 0, '0, '0);
    for (int k = 0; k < 159; k++) begin
      r = 0; lv = 0; d = '0; p = '0;
      if (k == 1) begin lv = 1; d = 16'h1234; p = 4'b0010; end
      else if (k >= 3 && k <= 24) begin lv = 1; d = 16'hABCD; p = 4'b1000; end
      else if (k == 95) begin lv = 1; d = 16'h5E7F; p = 4'b0001; end
      else if (k == 150) begin lv = 1; d = 16'h9999; p = 4'b1111; end
      if (k == 158) r = 1;
      step(r, lv, d, p);
    end
    for (int k = 0; k < 52; k++) step(0, 0, '0, '0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
